// File: rtl/clic_claim_sequencer.sv
// Picks the highest-ranked eligible interrupt, offers it to the hart over valid/ready,
// and pulses a one-hot pending clear for edge-triggered sources after acceptance.
module clic_claim_sequencer #(
  parameter int N_SOURCE   = 32,
  parameter int INTCTLBITS = 8,
  parameter int SRCW       = $clog2(N_SOURCE)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_SOURCE-1:0]      ip_i,
  input  logic [N_SOURCE-1:0]      ie_i,
  input  logic [N_SOURCE-1:0]      le_i,
  input  logic [N_SOURCE-1:0]      shv_i,
  input  logic [N_SOURCE-1:0][7:0] intctl_i,
  input  logic [N_SOURCE-1:0][1:0] intmode_i,
  input  logic [7:0]               mintthresh_i,
  output logic                     irq_valid_o,
  input  logic                     irq_ready_i,
  output logic [SRCW-1:0]          irq_id_o,
  output logic [7:0]               irq_level_o,
  output logic [1:0]               irq_priv_o,
  output logic                     irq_shv_o,
  output logic [N_SOURCE-1:0]      edge_clear_o
);

  localparam int KW = 11 + SRCW;
  localparam int P  = 1 << SRCW;
  localparam logic [7:0] LVL_MASK = 8'(8'hFF >> INTCTLBITS);

  typedef enum logic [1:0] {IDLE, OFFER, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [SRCW-1:0]       id_q;
  logic [7:0]            level_q;
  logic [1:0]            priv_q;
  logic                  shv_q;
  logic [N_SOURCE-1:0]   edge_clear_q, edge_clear_d;
  logic                  load;

  logic [N_SOURCE-1:0][7:0] lvl;
  logic [N_SOURCE-1:0]      elig;
  // Tree node key: {eligible, mode, level, id}; the eligible bit makes any candidate beat padding.
  logic [KW-1:0]            node [2*P-1];

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      if (gi < N_SOURCE) begin : g_src
        assign lvl[gi]        = intctl_i[gi] | LVL_MASK;
        assign elig[gi]       = ip_i[gi] & ie_i[gi] & (lvl[gi] > mintthresh_i);
        assign node[P-1+gi]   = {elig[gi], intmode_i[gi], lvl[gi], SRCW'(gi)};
      end else begin : g_pad
        assign node[P-1+gi]   = '0;
      end
    end
    for (gi = 0; gi < P-1; gi++) begin : g_node
      assign node[gi] = (node[2*gi+1] > node[2*gi+2]) ? node[2*gi+1] : node[2*gi+2];
    end
  endgenerate

  logic            win_valid;
  logic [SRCW-1:0] win_id;
  logic [7:0]      win_lvl;
  logic [1:0]      win_mode;

  assign win_valid = node[0][KW-1];
  assign win_id    = node[0][SRCW-1:0];
  assign win_lvl   = node[0][SRCW+7:SRCW];
  assign win_mode  = node[0][SRCW+9:SRCW+8];

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    edge_clear_d = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = OFFER;
          load    = 1'b1;
        end
      end
      OFFER: begin
        if (irq_ready_i) begin
          state_d = CLEAR;
          // Pulse is registered on the accept edge so the output never sees le_i combinationally.
          edge_clear_d[id_q] = le_i[id_q];
        end else if (!elig[id_q] || (win_id != id_q)) begin
          state_d = IDLE;
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      id_q         <= '0;
      level_q      <= '0;
      priv_q       <= '0;
      shv_q        <= 1'b0;
      edge_clear_q <= '0;
    end else begin
      state_q      <= state_d;
      edge_clear_q <= edge_clear_d;
      if (load) begin
        id_q    <= win_id;
        level_q <= win_lvl;
        priv_q  <= win_mode;
        shv_q   <= shv_i[win_id];
      end
    end
  end

  assign irq_valid_o  = (state_q == OFFER);
  assign irq_id_o     = id_q;
  assign irq_level_o  = level_q;
  assign irq_priv_o   = priv_q;
  assign irq_shv_o    = shv_q;
  assign edge_clear_o = edge_clear_q;

endmodule

// File: tb/tb_clic_claim_sequencer.sv
// Directed bench for clic_claim_sequencer: full-width instance plus an INTCTLBITS=2 instance.
module tb_clic_claim_sequencer;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      ip, ie, le, shv;
  logic [31:0][7:0] intctl;
  logic [31:0][1:0] intmode;
  logic [7:0]       thresh;
  logic             ready;

  logic             valid_a, valid_b, shv_a, shv_b;
  logic [4:0]       id_a, id_b;
  logic [7:0]       level_a, level_b;
  logic [1:0]       priv_a, priv_b;
  logic [31:0]      clr_a, clr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clic_claim_sequencer #(.N_SOURCE(32), .INTCTLBITS(8)) dut (
    .clk_i(clk), .rst_i(rst), .ip_i(ip), .ie_i(ie), .le_i(le), .shv_i(shv),
    .intctl_i(intctl), .intmode_i(intmode), .mintthresh_i(thresh),
    .irq_valid_o(valid_a), .irq_ready_i(ready), .irq_id_o(id_a),
    .irq_level_o(level_a), .irq_priv_o(priv_a), .irq_shv_o(shv_a),
    .edge_clear_o(clr_a)
  );

  clic_claim_sequencer #(.N_SOURCE(32), .INTCTLBITS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .ip_i(ip), .ie_i(ie), .le_i(le), .shv_i(shv),
    .intctl_i(intctl), .intmode_i(intmode), .mintthresh_i(thresh),
    .irq_valid_o(valid_b), .irq_ready_i(ready), .irq_id_o(id_b),
    .irq_level_o(level_b), .irq_priv_o(priv_b), .irq_shv_o(shv_b),
    .edge_clear_o(clr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rst deasserted just after a falling edge with all inputs idle.
  task automatic reset_dut();
    rst = 1'b1;
    ip = '0; ie = '0; le = '0; shv = '0;
    intctl = '0; intmode = '0; thresh = 8'h00; ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic enable_src(input int s, input logic [7:0] ctl, input logic [1:0] md, input logic edge_trig);
    ip[s] = 1'b1; ie[s] = 1'b1; intctl[s] = ctl; intmode[s] = md; le[s] = edge_trig;
  endtask

  initial begin
    reset_dut();
    check("reset_valid", 32'(valid_a), 32'd0);
    check("reset_id",    32'(id_a),    32'd0);
    check("reset_level", 32'(level_a), 32'd0);
    check("reset_priv",  32'(priv_a),  32'd0);
    check("reset_shv",   32'(shv_a),   32'd0);
    check("reset_clear", clr_a,        32'd0);

    // Basic edge-triggered claim on source 5
    enable_src(5, 8'h80, 2'd0, 1'b1);
    shv[5] = 1'b1;
    step(1);
    check("basic_valid", 32'(valid_a), 32'd1);
    check("basic_id",    32'(id_a),    32'd5);
    check("basic_level", 32'(level_a), 32'h80);
    check("basic_shv",   32'(shv_a),   32'd1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("clear_valid", 32'(valid_a), 32'd0);
    check("clear_pulse", clr_a,        32'h20);
    step(1);
    check("bubble_valid", 32'(valid_a), 32'd0);
    check("bubble_pulse", clr_a,        32'h0);
    step(1);
    check("reoffer_valid", 32'(valid_a), 32'd1);
    check("reoffer_pulse", clr_a,        32'h0);
    ip[5] = 1'b0;
    step(1);
    check("withdraw_valid", 32'(valid_a), 32'd0);

    // Tie on level and mode: higher id wins; then a higher level takes over
    reset_dut();
    enable_src(3, 8'h40, 2'd3, 1'b0);
    enable_src(9, 8'h40, 2'd3, 1'b0);
    step(1);
    check("tie_id",   32'(id_a),   32'd9);
    check("tie_priv", 32'(priv_a), 32'd3);
    intctl[3] = 8'h60;
    step(1);
    check("tie_withdraw", 32'(valid_a), 32'd0);
    step(1);
    check("tie_newwin_valid", 32'(valid_a), 32'd1);
    check("tie_newwin_id",    32'(id_a),    32'd3);
    check("tie_newwin_level", 32'(level_a), 32'h60);
    enable_src(12, 8'hFF, 2'd1, 1'b0);
    step(2);
    check("mode_beats_level_valid", 32'(valid_a), 32'd1);
    check("mode_beats_level_id",    32'(id_a),    32'd3);

    // Threshold boundary with INTCTLBITS=2: 0x40 reads as 0x7F
    reset_dut();
    enable_src(4, 8'h40, 2'd0, 1'b0);
    thresh = 8'h7F;
    step(2);
    check("thresh_equal_novalid", 32'(valid_b), 32'd0);
    thresh = 8'h7E;
    step(1);
    check("thresh_below_valid", 32'(valid_b), 32'd1);
    check("thresh_below_id",    32'(id_b),    32'd4);
    check("thresh_below_level", 32'(level_b), 32'h7F);
    check("thresh_full_novalid", 32'(valid_a), 32'd0);

    // Preemption by a higher level source
    reset_dut();
    enable_src(2, 8'h20, 2'd0, 1'b1);
    step(1);
    check("pre_id",    32'(id_a),    32'd2);
    check("pre_level", 32'(level_a), 32'h20);
    enable_src(7, 8'h90, 2'd0, 1'b1);
    step(1);
    check("pre_drop", 32'(valid_a), 32'd0);
    step(1);
    check("pre_new_valid", 32'(valid_a), 32'd1);
    check("pre_new_id",    32'(id_a),    32'd7);

    // Ready and loss of pending in the same cycle: handshake wins
    reset_dut();
    enable_src(2, 8'h20, 2'd0, 1'b1);
    step(1);
    check("sim_valid", 32'(valid_a), 32'd1);
    ready = 1'b1;
    ip[2] = 1'b0;
    step(1);
    ready = 1'b0;
    check("sim_clear_valid", 32'(valid_a), 32'd0);
    check("sim_clear_pulse", clr_a,        32'h4);

    // Level-triggered: bubble without pulse, re-offer 3 cycles after accept
    reset_dut();
    enable_src(6, 8'h50, 2'd0, 1'b0);
    step(1);
    check("lvl_valid", 32'(valid_a), 32'd1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("lvl_clear_pulse", clr_a,        32'h0);
    check("lvl_clear_valid", 32'(valid_a), 32'd0);
    step(1);
    check("lvl_idle_valid", 32'(valid_a), 32'd0);
    step(1);
    check("lvl_reoffer_valid", 32'(valid_a), 32'd1);
    check("lvl_reoffer_id",    32'(id_a),    32'd6);

    // Asynchronous reset mid-OFFER
    #2 rst = 1'b1;
    #1;
    check("rst_offer_valid", 32'(valid_a), 32'd0);
    check("rst_offer_id",    32'(id_a),    32'd0);
    check("rst_offer_level", 32'(level_a), 32'd0);
    reset_dut();

    // Asynchronous reset mid-CLEAR kills the pulse
    enable_src(10, 8'hA0, 2'd0, 1'b1);
    step(1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("rstclr_pulse_before", clr_a, 32'h400);
    #2 rst = 1'b1;
    #1;
    check("rstclr_pulse_after", clr_a, 32'h0);
    reset_dut();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
